// File: rtl/conv_event_scheduler.sv
// CONV2D event sequencer: pops FIFO events, expands spike events into kernel/fmap jobs, handshakes timestep events.
// Optional statistics counters are built when CONV_SCHED_STATS_EN is defined; otherwise stat_* are tied to 0.
module conv_event_scheduler #(
   parameter int KERNEL_SIZE         = 3,
   parameter int IN_CHANNELS         = 2,
   parameter int IMG_HEIGHT          = 8,
   parameter int IMG_WIDTH           = 8,
   parameter int BITS_PER_COORDINATE = 4,
   localparam int KA_CLOG = $clog2(KERNEL_SIZE * KERNEL_SIZE * IN_CHANNELS),
   localparam int FA_CLOG = $clog2(IMG_HEIGHT * IMG_WIDTH),
   localparam int KA_W    = (KA_CLOG < 1) ? 1 : KA_CLOG,
   localparam int FA_W    = (FA_CLOG < 1) ? 1 : FA_CLOG,
   localparam int DW      = 2 * BITS_PER_COORDINATE + IN_CHANNELS + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic            fifo_empty,
   output logic            fifo_read_en,
   input  logic [DW-1:0]   fifo_read_data,
   output logic            job_valid,
   input  logic            job_ready,
   output logic [KA_W-1:0] job_kernel_addr,
   output logic [FA_W-1:0] job_fmap_addr,
   output logic            ts_req,
   input  logic            ts_ack,
   output logic            event_done,
   output logic            busy,
   output logic [31:0]     stat_events,
   output logic [31:0]     stat_jobs,
   output logic [31:0]     stat_dropped
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LOAD    = 3'd1;
   localparam logic [2:0] S_JOB     = 3'd2;
   localparam logic [2:0] S_NEXT_CH = 3'd3;
   localparam logic [2:0] S_TS_WAIT = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam int          B    = BITS_PER_COORDINATE;
   localparam int          CW   = B + 2;
   localparam int          KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam int          CH_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
   localparam int unsigned P    = (KERNEL_SIZE - 1) / 2;
   localparam int unsigned KU   = KERNEL_SIZE;
   localparam int unsigned KK   = KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned IW   = IMG_WIDTH;
   localparam int unsigned IH   = IMG_HEIGHT;

   logic [2:0]             r_state;
   logic [B-1:0]           r_x;
   logic [B-1:0]           r_y;
   logic [IN_CHANNELS-1:0] r_mask;
   logic [CH_W-1:0]        r_ch;
   logic [KW-1:0]          r_kx;
   logic [KW-1:0]          r_ky;

   logic                   w_pop;
   logic signed [CW-1:0]   w_tx;
   logic signed [CW-1:0]   w_ty;
   logic                   w_x_in;
   logic                   w_y_in;
   logic                   w_in;
   logic                   w_in_job;
   logic                   w_job_valid;
   logic                   w_adv;
   logic                   w_last_kx;
   logic                   w_last_ky;
   logic [CH_W-1:0]        w_lsb_idx;
   logic                   w_found;

   assign w_pop = (r_state == S_IDLE) && enable && !fifo_empty;

   // Tap target: two extra bits so x+P-kx can go negative or past the edge without wrapping.
   assign w_tx = $signed({2'b00, r_x}) + $signed(CW'(P)) - $signed(CW'(r_kx));
   assign w_ty = $signed({2'b00, r_y}) + $signed(CW'(P)) - $signed(CW'(r_ky));

   assign w_x_in = !w_tx[CW-1] && (32'(w_tx[CW-2:0]) < IW);
   assign w_y_in = !w_ty[CW-1] && (32'(w_ty[CW-2:0]) < IH);
   assign w_in   = w_x_in && w_y_in;

   assign w_in_job    = (r_state == S_JOB);
   assign w_job_valid = w_in_job && w_in;
   assign w_adv       = w_in_job && (!w_in || job_ready);
   assign w_last_kx   = (r_kx == KW'(KERNEL_SIZE - 1));
   assign w_last_ky   = (r_ky == KW'(KERNEL_SIZE - 1));

   always_comb begin
      w_lsb_idx = '0;
      w_found   = 1'b0;
      for (int unsigned i = 0; i < IN_CHANNELS; i++) begin
         if (r_mask[i] && !w_found) begin
            w_lsb_idx = CH_W'(i);
            w_found   = 1'b1;
         end
      end
   end

   assign fifo_read_en = w_pop;
   assign job_valid    = w_job_valid;
   assign ts_req       = (r_state == S_TS_WAIT);
   assign event_done   = (r_state == S_DONE);
   assign busy         = (r_state != S_IDLE);

   // Addresses are forced to zero whenever no job is presented; they only depend on registers while valid.
   assign job_kernel_addr = w_job_valid
      ? KA_W'(32'(r_ch) * KK + 32'(r_ky) * KU + 32'(r_kx)) : '0;
   assign job_fmap_addr = w_job_valid
      ? FA_W'(32'(w_ty[CW-2:0]) * IW + 32'(w_tx[CW-2:0])) : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_mask  <= '0;
         r_ch    <= '0;
         r_kx    <= '0;
         r_ky    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) r_state <= S_LOAD;
            end
            S_LOAD: begin
               if (fifo_read_data[DW-1]) begin
                  r_state <= S_TS_WAIT;
               end else begin
                  r_x     <= fifo_read_data[DW-2 -: B];
                  r_y     <= fifo_read_data[DW-2-B -: B];
                  r_mask  <= fifo_read_data[IN_CHANNELS-1:0];
                  r_state <= S_NEXT_CH;
               end
            end
            S_NEXT_CH: begin
               if (r_mask == '0) begin
                  r_state <= S_DONE;
               end else begin
                  r_ch    <= w_lsb_idx;
                  r_kx    <= '0;
                  r_ky    <= '0;
                  r_state <= S_JOB;
               end
            end
            S_JOB: begin
               if (w_adv) begin
                  if (w_last_kx) begin
                     r_kx <= '0;
                     if (w_last_ky) begin
                        r_mask  <= r_mask & ~(IN_CHANNELS'(1) << r_ch);
                        r_state <= S_NEXT_CH;
                     end else begin
                        r_ky <= r_ky + KW'(1);
                     end
                  end else begin
                     r_kx <= r_kx + KW'(1);
                  end
               end
            end
            S_TS_WAIT: begin
               if (ts_ack) r_state <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CONV_SCHED_STATS_EN
   logic [31:0] r_stat_events;
   logic [31:0] r_stat_jobs;
   logic [31:0] r_stat_dropped;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_events  <= '0;
         r_stat_jobs    <= '0;
         r_stat_dropped <= '0;
      end else begin
         if (r_state == S_DONE)        r_stat_events  <= r_stat_events + 32'd1;
         if (w_job_valid && job_ready) r_stat_jobs    <= r_stat_jobs + 32'd1;
         if (w_in_job && !w_in)        r_stat_dropped <= r_stat_dropped + 32'd1;
      end
   end

   assign stat_events  = r_stat_events;
   assign stat_jobs    = r_stat_jobs;
   assign stat_dropped = r_stat_dropped;
`else
   assign stat_events  = '0;
   assign stat_jobs    = '0;
   assign stat_dropped = '0;
`endif

endmodule

// File: tb/tb_conv_event_scheduler.sv
// Directed self-checking bench for conv_event_scheduler (K=3, 2 channels, 8x8 image, 4-bit coordinates).
module tb_conv_event_scheduler;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        fifo_empty;
   logic        fifo_read_en;
   logic [10:0] fifo_read_data;
   logic        job_valid;
   logic        job_ready;
   logic [4:0]  job_kernel_addr;
   logic [5:0]  job_fmap_addr;
   logic        ts_req;
   logic        ts_ack;
   logic        event_done;
   logic        busy;
   logic [31:0] stat_events;
   logic [31:0] stat_jobs;
   logic [31:0] stat_dropped;

   int errors = 0;
   int checks = 0;
   int w;

   int fc[9] = '{36, 35, 34, 28, 27, 26, 20, 19, 18};

   conv_event_scheduler #(
      .KERNEL_SIZE(3),
      .IN_CHANNELS(2),
      .IMG_HEIGHT(8),
      .IMG_WIDTH(8),
      .BITS_PER_COORDINATE(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .fifo_empty(fifo_empty),
      .fifo_read_en(fifo_read_en),
      .fifo_read_data(fifo_read_data),
      .job_valid(job_valid),
      .job_ready(job_ready),
      .job_kernel_addr(job_kernel_addr),
      .job_fmap_addr(job_fmap_addr),
      .ts_req(ts_req),
      .ts_ack(ts_ack),
      .event_done(event_done),
      .busy(busy),
      .stat_events(stat_events),
      .stat_jobs(stat_jobs),
      .stat_dropped(stat_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_stats(input string tag, input int ev, input int jb, input int dr);
`ifdef CONV_SCHED_STATS_EN
      chk({tag, ".stat_events"},  stat_events,  32'(ev));
      chk({tag, ".stat_jobs"},    stat_jobs,    32'(jb));
      chk({tag, ".stat_dropped"}, stat_dropped, 32'(dr));
`else
      chk({tag, ".stat_events"},  stat_events,  32'(0 * ev));
      chk({tag, ".stat_jobs"},    stat_jobs,    32'(0 * jb));
      chk({tag, ".stat_dropped"}, stat_dropped, 32'(0 * dr));
`endif
   endtask

   // Called in IDLE; returns in the cycle after LOAD.
   task automatic pop_event(input string tag, input logic [10:0] d);
      fifo_read_data = d;
      fifo_empty     = 1'b0;
      enable         = 1'b1;
      #1;
      chk({tag, ".pop"}, 32'(fifo_read_en), 32'd1);
      step();
      fifo_empty = 1'b1;
      #1;
      chk({tag, ".load_busy"},  32'(busy),         32'd1);
      chk({tag, ".load_nopop"}, 32'(fifo_read_en), 32'd0);
      chk({tag, ".load_ts"},    32'(ts_req),       32'd0);
      step();
   endtask

   task automatic get_job(input string tag, input int ek, input int ef, input int exp_wait);
      int waited;
      waited = 0;
      while (!job_valid && waited < 8) begin
         step();
         waited++;
      end
      chk({tag, ".wait"},  32'(waited),          32'(exp_wait));
      chk({tag, ".valid"}, 32'(job_valid),       32'd1);
      chk({tag, ".kaddr"}, 32'(job_kernel_addr), 32'(ek));
      chk({tag, ".faddr"}, 32'(job_fmap_addr),   32'(ef));
      step();
   endtask

   task automatic finish_event(input string tag, input int n_pre);
      for (int i = 0; i < n_pre; i++) begin
         chk({tag, ".pre_done"},  32'(event_done), 32'd0);
         chk({tag, ".pre_valid"}, 32'(job_valid),  32'd0);
         step();
      end
      chk({tag, ".done"},      32'(event_done), 32'd1);
      chk({tag, ".done_busy"}, 32'(busy),       32'd1);
      step();
      chk({tag, ".idle_done"}, 32'(event_done), 32'd0);
      chk({tag, ".idle_busy"}, 32'(busy),       32'd0);
   endtask

   initial begin
      rst_n          = 1'b0;
      enable         = 1'b0;
      fifo_empty     = 1'b1;
      fifo_read_data = '0;
      job_ready      = 1'b1;
      ts_ack         = 1'b0;
      step();
      step();
      chk("rst.fifo_read_en", 32'(fifo_read_en),    32'd0);
      chk("rst.job_valid",    32'(job_valid),       32'd0);
      chk("rst.kaddr",        32'(job_kernel_addr), 32'd0);
      chk("rst.faddr",        32'(job_fmap_addr),   32'd0);
      chk("rst.ts_req",       32'(ts_req),          32'd0);
      chk("rst.event_done",   32'(event_done),      32'd0);
      chk("rst.busy",         32'(busy),            32'd0);
      chk_stats("rst", 0, 0, 0);
      rst_n = 1'b1;
      step();

      // Centre event, channel 0 only: nine back-to-back jobs.
      pop_event("centre", {1'b0, 4'd3, 4'd3, 2'b01});
      for (int i = 0; i < 9; i++) get_job("centre", i, fc[i], (i == 0) ? 1 : 0);
      finish_event("centre", 1);
      chk_stats("centre", 1, 9, 0);

      // Corner event, channel 1: four jobs, five dropped taps.
      pop_event("corner", {1'b0, 4'd0, 4'd0, 2'b10});
      get_job("corner0", 9,  9, 1);
      get_job("corner1", 10, 8, 0);
      get_job("corner2", 12, 1, 1);
      get_job("corner3", 13, 0, 0);
      finish_event("corner", 5);
      chk_stats("corner", 2, 13, 5);

      // Both channels at the centre: one idle NEXT_CH cycle between the two runs.
      pop_event("dual", {1'b0, 4'd3, 4'd3, 2'b11});
      for (int i = 0; i < 9; i++) get_job("dual_c0", i,     fc[i], (i == 0) ? 1 : 0);
      for (int i = 0; i < 9; i++) get_job("dual_c1", 9 + i, fc[i], (i == 0) ? 1 : 0);
      finish_event("dual", 1);
      chk_stats("dual", 3, 31, 5);

      // A stray ack in IDLE must not start anything.
      enable = 1'b1;
      ts_ack = 1'b1;
      step();
      chk("stray_ack.busy", 32'(busy), 32'd0);
      ts_ack = 1'b0;

      // Timestep event, ack arrives in the fifth request cycle; FIFO is non-empty meanwhile.
      pop_event("ts", {1'b1, 10'd0});
      fifo_read_data = {1'b0, 4'd3, 4'd3, 2'b01};
      fifo_empty     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) ts_ack = 1'b1;
         #1;
         chk("ts.req",   32'(ts_req),       32'd1);
         chk("ts.valid", 32'(job_valid),    32'd0);
         chk("ts.nopop", 32'(fifo_read_en), 32'd0);
         chk("ts.done",  32'(event_done),   32'd0);
         step();
      end
      ts_ack = 1'b0;
      #1;
      chk("ts_done.req",   32'(ts_req),       32'd0);
      chk("ts_done.done",  32'(event_done),   32'd1);
      chk("ts_done.nopop", 32'(fifo_read_en), 32'd0);
      step();
      chk_stats("ts", 4, 31, 5);

      // Backpressure on the third job for four cycles.
      pop_event("stall", {1'b0, 4'd3, 4'd3, 2'b01});
      get_job("stall0", 0, 36, 1);
      get_job("stall1", 1, 35, 0);
      job_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall.hold_valid", 32'(job_valid),       32'd1);
         chk("stall.hold_kaddr", 32'(job_kernel_addr), 32'd2);
         chk("stall.hold_faddr", 32'(job_fmap_addr),   32'd34);
         step();
      end
      job_ready = 1'b1;
      for (int i = 2; i < 9; i++) get_job("stall_rest", i, fc[i], 0);
      finish_event("stall", 1);
      chk_stats("stall", 5, 40, 5);

      // Reset in the middle of an event.
      pop_event("mid", {1'b0, 4'd3, 4'd3, 2'b01});
      get_job("mid0", 0, 36, 1);
      get_job("mid1", 1, 35, 0);
      enable     = 1'b0;
      fifo_empty = 1'b0;
      rst_n      = 1'b0;
      #1;
      chk("midrst.job_valid",  32'(job_valid),       32'd0);
      chk("midrst.kaddr",      32'(job_kernel_addr), 32'd0);
      chk("midrst.faddr",      32'(job_fmap_addr),   32'd0);
      chk("midrst.busy",       32'(busy),            32'd0);
      chk("midrst.ts_req",     32'(ts_req),          32'd0);
      chk("midrst.event_done", 32'(event_done),      32'd0);
      chk("midrst.fifo_rd",    32'(fifo_read_en),    32'd0);
      chk_stats("midrst", 0, 0, 0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("disabled.nopop", 32'(fifo_read_en), 32'd0);
         chk("disabled.busy",  32'(busy),         32'd0);
         step();
      end
      enable = 1'b1;
      #1;
      chk("enable.pop", 32'(fifo_read_en), 32'd1);
      step();
      fifo_empty = 1'b1;
      #1;
      chk("enable.load_busy", 32'(busy), 32'd1);

      w = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
